// File: rtl/predictor_saltos.sv
// Dynamic branch predictor: a 2-bit BHT and a tagged BTB looked up at fetch,
// trained at EX resolution, with a registered one-cycle redirect on mispredict.
module predictor_saltos #(
   parameter int ENTRADAS = 16,
   parameter int IDX_W    = $clog2(ENTRADAS),
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      pc_busqueda,
   output logic             pred_tomado,
   output logic [31:0]      pred_destino,
   input  logic             res_valido,
   input  logic [31:0]      res_pc,
   input  logic             res_tomado,
   input  logic [31:0]      res_destino,
   input  logic             res_pred_tomado,
   input  logic [31:0]      res_pred_destino,
   output logic             redirigir,
   output logic [31:0]      pc_redir,
   output logic [CNT_W-1:0] total_saltos,
   output logic [CNT_W-1:0] total_fallos
);

   localparam int TAG_W = 30 - IDX_W;

   logic [1:0]       bht_q   [ENTRADAS];
   logic             valid_q [ENTRADAS];
   logic [TAG_W-1:0] tag_q   [ENTRADAS];
   logic [31:0]      dest_q  [ENTRADAS];

   logic             redir_q, redir_d;
   logic [31:0]      pc_redir_q, pc_redir_d;
   logic [CNT_W-1:0] saltos_q, saltos_d;
   logic [CNT_W-1:0] fallos_q, fallos_d;

   logic [IDX_W-1:0] idx_f, idx_r;
   logic [TAG_W-1:0] tag_f, tag_r;
   logic             hit_f;
   logic [1:0]       bht_d;
   logic [31:0]      correct_pc;
   logic             fallo;

   // Low PC bits are always zero for RV32I, and the direction bit used at fetch
   // is already folded into res_pred_destino.
   logic unused_bits;
   assign unused_bits = ^{pc_busqueda[1:0], res_pc[1:0], res_pred_tomado};

   assign idx_f = pc_busqueda[IDX_W+1:2];
   assign tag_f = pc_busqueda[31:IDX_W+2];
   assign idx_r = res_pc[IDX_W+1:2];
   assign tag_r = res_pc[31:IDX_W+2];

   assign hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
   assign pred_tomado  = hit_f && bht_q[idx_f][1];
   assign pred_destino = pred_tomado ? dest_q[idx_f] : pc_busqueda + 32'd4;

   assign correct_pc = res_tomado ? res_destino : res_pc + 32'd4;
   assign fallo      = (res_pred_destino != correct_pc);

   always_comb begin
      bht_d      = bht_q[idx_r];
      redir_d    = 1'b0;
      pc_redir_d = pc_redir_q;
      saltos_d   = saltos_q;
      fallos_d   = fallos_q;
      if (res_valido) begin
         if (res_tomado && bht_q[idx_r] != 2'b11)
            bht_d = bht_q[idx_r] + 2'd1;
         else if (!res_tomado && bht_q[idx_r] != 2'b00)
            bht_d = bht_q[idx_r] - 2'd1;
         redir_d    = fallo;
         pc_redir_d = correct_pc;
         if (saltos_q != '1)
            saltos_d = saltos_q + 1'b1;
         if (fallo && fallos_q != '1)
            fallos_d = fallos_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < ENTRADAS; k++) begin
            bht_q[k]   <= 2'b01;
            valid_q[k] <= 1'b0;
            tag_q[k]   <= '0;
            dest_q[k]  <= '0;
         end
      end else if (res_valido) begin
         bht_q[idx_r] <= bht_d;
         if (res_tomado) begin
            valid_q[idx_r] <= 1'b1;
            tag_q[idx_r]   <= tag_r;
            dest_q[idx_r]  <= res_destino;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redir_q    <= 1'b0;
         pc_redir_q <= '0;
         saltos_q   <= '0;
         fallos_q   <= '0;
      end else begin
         redir_q    <= redir_d;
         pc_redir_q <= pc_redir_d;
         saltos_q   <= saltos_d;
         fallos_q   <= fallos_d;
      end
   end

   assign redirigir    = redir_q;
   assign pc_redir     = pc_redir_q;
   assign total_saltos = saltos_q;
   assign total_fallos = fallos_q;

endmodule

// File: tb/tb_predictor_saltos.sv
// Directed bench for predictor_saltos; 4-bit counters make saturation reachable.
module tb_predictor_saltos;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_busqueda;
   logic        pred_tomado;
   logic [31:0] pred_destino;
   logic        res_valido;
   logic [31:0] res_pc;
   logic        res_tomado;
   logic [31:0] res_destino;
   logic        res_pred_tomado;
   logic [31:0] res_pred_destino;
   logic        redirigir;
   logic [31:0] pc_redir;
   logic [3:0]  total_saltos;
   logic [3:0]  total_fallos;

   int checks   = 0;
   int failures = 0;
   int exp_s    = 0;
   int exp_f    = 0;

   always #5 clk = ~clk;

   predictor_saltos #(.ENTRADAS(16), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .pc_busqueda(pc_busqueda), .pred_tomado(pred_tomado), .pred_destino(pred_destino),
      .res_valido(res_valido), .res_pc(res_pc), .res_tomado(res_tomado),
      .res_destino(res_destino), .res_pred_tomado(res_pred_tomado),
      .res_pred_destino(res_pred_destino),
      .redirigir(redirigir), .pc_redir(pc_redir),
      .total_saltos(total_saltos), .total_fallos(total_fallos)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   // Present one resolution, clock it, then drop res_valido and sample.
   task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] dst,
                          input logic [31:0] pdst);
      res_valido       = 1'b1;
      res_pc           = pc;
      res_tomado       = tk;
      res_destino      = dst;
      res_pred_tomado  = (pdst != pc + 32'd4);
      res_pred_destino = pdst;
      @(posedge clk); #1;
      res_valido = 1'b0;
      $display("resolve pc=0x%08h tk=%0b dst=0x%08h pdst=0x%08h -> redir=%0b pc_redir=0x%08h saltos=%0d fallos=%0d",
               pc, tk, dst, pdst, redirigir, pc_redir, total_saltos, total_fallos);
   endtask

   task automatic lookup(input string tag, input logic [31:0] pc, input logic tk,
                         input logic [31:0] dst);
      pc_busqueda = pc;
      #1;
      $display("lookup pc=0x%08h -> pred=%0b dest=0x%08h", pc, pred_tomado, pred_destino);
      chk({tag, "_tk"}, {31'd0, pred_tomado}, {31'd0, tk});
      chk({tag, "_dst"}, pred_destino, dst);
   endtask

   task automatic chk_state(input string tag, input logic rd, input logic [31:0] prd,
                            input int s, input int f);
      chk({tag, "_redir"}, {31'd0, redirigir}, {31'd0, rd});
      chk({tag, "_pcredir"}, pc_redir, prd);
      chk({tag, "_saltos"}, {28'd0, total_saltos}, s);
      chk({tag, "_fallos"}, {28'd0, total_fallos}, f);
   endtask

   initial begin
      rst_n = 1'b0;
      pc_busqueda = 32'h100;
      res_valido = 1'b0; res_pc = '0; res_tomado = 1'b0; res_destino = '0;
      res_pred_tomado = 1'b0; res_pred_destino = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      lookup("rst_look", 32'h100, 1'b0, 32'h104);
      chk_state("rst", 1'b0, 32'h0, 0, 0);

      // First taken resolution mispredicts; bht 01->10
      resolve(32'h100, 1'b1, 32'h40, 32'h104);
      chk_state("first", 1'b1, 32'h40, 1, 1);
      lookup("first_look", 32'h100, 1'b1, 32'h40);

      // Four correctly predicted taken resolutions, back to back
      for (int i = 0; i < 4; i++) begin
         resolve(32'h100, 1'b1, 32'h40, 32'h40);
         chk("sat_redir", {31'd0, redirigir}, 32'd0);
      end
      chk_state("sat", 1'b0, 32'h40, 5, 1);

      // Not-taken after saturation: 11->10, still predicted taken
      resolve(32'h100, 1'b0, 32'h40, 32'h40);
      chk_state("nt1", 1'b1, 32'h104, 6, 2);
      lookup("nt1_look", 32'h100, 1'b1, 32'h40);

      // Second not-taken, correctly predicted: 10->01
      resolve(32'h100, 1'b0, 32'h40, 32'h104);
      chk_state("nt2", 1'b0, 32'h104, 7, 2);
      lookup("nt2_look", 32'h100, 1'b0, 32'h104);

      // Alias: 0x140 shares index 0 with 0x100
      resolve(32'h100, 1'b1, 32'h40, 32'h104);
      chk_state("alias_tr", 1'b1, 32'h40, 8, 3);
      lookup("alias_140", 32'h140, 1'b0, 32'h144);
      lookup("alias_100", 32'h100, 1'b1, 32'h40);

      // Same-cycle lookup and update: no bypass
      pc_busqueda = 32'h208;
      res_valido = 1'b1; res_pc = 32'h208; res_tomado = 1'b1; res_destino = 32'h300;
      res_pred_tomado = 1'b0; res_pred_destino = 32'h20C;
      #1;
      chk("same_pre_tk", {31'd0, pred_tomado}, 32'd0);
      chk("same_pre_dst", pred_destino, 32'h20C);
      @(posedge clk); #1;
      res_valido = 1'b0;
      $display("same-cycle update pc=0x208 -> pred=%0b dest=0x%08h", pred_tomado, pred_destino);
      chk("same_post_tk", {31'd0, pred_tomado}, 32'd1);
      chk("same_post_dst", pred_destino, 32'h300);
      chk_state("same", 1'b1, 32'h300, 9, 4);

      // Back-to-back mispredicts: redirect stays high with new pc_redir
      res_valido = 1'b1; res_pc = 32'h300; res_tomado = 1'b0; res_destino = 32'h0;
      res_pred_tomado = 1'b1; res_pred_destino = 32'h500;
      @(posedge clk); #1;
      chk_state("b2b_1", 1'b1, 32'h304, 10, 5);
      resolve(32'h20C, 1'b1, 32'h400, 32'h210);
      chk_state("b2b_2", 1'b1, 32'h400, 11, 6);

      // Idle cycle: pulse drops, pc_redir holds
      @(posedge clk); #1;
      $display("idle -> redir=%0b pc_redir=0x%08h", redirigir, pc_redir);
      chk_state("idle", 1'b0, 32'h400, 11, 6);

      // PC wrap at the top of the address space
      resolve(32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
      chk_state("wrap_ok", 1'b0, 32'h0, 12, 6);
      resolve(32'hFFFF_FFFC, 1'b0, 32'h0, 32'h8);
      chk_state("wrap_bad", 1'b1, 32'h0, 13, 7);
      lookup("wrap_look", 32'hFFFF_FFFC, 1'b0, 32'h0);

      // Counter saturation at 4'hF
      exp_s = 13; exp_f = 7;
      for (int i = 0; i < 10; i++) begin
         resolve(32'h10, 1'b0, 32'h0, 32'h0);
         exp_s = (exp_s == 15) ? 15 : exp_s + 1;
         exp_f = (exp_f == 15) ? 15 : exp_f + 1;
         chk("satcnt_redir", {31'd0, redirigir}, 32'd1);
      end
      chk_state("satcnt", 1'b1, 32'h14, exp_s, exp_f);
      chk("satcnt_s15", {28'd0, total_saltos}, 32'd15);
      chk("satcnt_f15", {28'd0, total_fallos}, 32'd15);

      // Asynchronous reset while a redirect is pending
      resolve(32'h100, 1'b0, 32'h0, 32'h40);
      chk("prerst_redir", {31'd0, redirigir}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      $display("async reset -> redir=%0b pc_redir=0x%08h", redirigir, pc_redir);
      chk_state("midrst", 1'b0, 32'h0, 0, 0);
      lookup("midrst_100", 32'h100, 1'b0, 32'h104);
      lookup("midrst_208", 32'h208, 1'b0, 32'h20C);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk_state("postrst", 1'b0, 32'h0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/predictor_saltos.md
Name: predictor_saltos

Overview:
- Dynamic branch predictor with resolution-side feedback for the pipelined RV32 core.
- Fetch side: looks up the current PC and returns a taken/not-taken prediction plus a target.
- Execute side: takes the branch-comparator outcome (taken bit) and the computed target, trains the tables, and issues a registered redirect when the prediction was wrong.
- Sits between the PC/fetch stage and the branch comparator in EX; it closes the loop on the comparator's result.

Parameters:
ENTRADAS, 16, number of BHT/BTB entries; power of two, 4..256.
IDX_W, $clog2(ENTRADAS), index width; index = pc[IDX_W+1:2].
CNT_W, 32, width of the statistics counters.

Ports:
clk  in  1  clock, all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
pc_busqueda  in  32  fetch-stage PC to predict
pred_tomado  out  1  prediction: taken (combinational from table state)
pred_destino  out  32  predicted next PC
res_valido  in  1  a conditional branch resolves this cycle
res_pc  in  32  PC of the resolving branch
res_tomado  in  1  actual outcome from the branch comparator
res_destino  in  32  actual taken target computed in EX
res_pred_tomado  in  1  prediction that was used for this branch
res_pred_destino  in  32  predicted next PC that was used
redirigir  out  1  one-cycle flush/redirect pulse
pc_redir  out  32  correct next PC accompanying redirigir
total_saltos  out  CNT_W  resolved branch count
total_fallos  out  CNT_W  misprediction count

Behaviour:
- Reset (async assert, sync-safe deassert):
  - every BHT counter = 2'b01 (weakly not-taken);
  - every BTB valid = 0;
  - redirigir = 0; pc_redir = 0;
  - total_saltos = total_fallos = 0.
- Lookup is combinational from registered state, index i = pc_busqueda[IDX_W+1:2], tag = pc_busqueda[31:IDX_W+2]:
  - hit = valid[i] && tag matches;
  - pred_tomado = hit && bht[i][1];
  - pred_destino = pred_tomado ? btb_dest[i] : pc_busqueda + 4.
- Resolution, on the rising edge when res_valido = 1, with index j from res_pc:
  - bht[j]: 2-bit saturating update. Increment if res_tomado, decrement otherwise; stays at 11 and at 00.
  - If res_tomado: btb valid[j] = 1, tag[j] = res_pc tag, dest[j] = res_destino. Overwrites on alias.
  - If not taken: the BTB entry is untouched.
  - If the tag mismatched on a previous entry, the counter still updates (no tag check on BHT).
  - correct_pc = res_tomado ? res_destino : res_pc + 4.
  - fallo = (res_pred_destino != correct_pc). This covers both direction and target mispredicts.
  - Next cycle: redirigir = fallo and pc_redir = correct_pc. Latency is exactly 1 cycle.
  - total_saltos += 1; total_fallos += fallo. Both saturate at all-ones and do not wrap.
- When res_valido = 0: redirigir = 0 the next cycle, pc_redir holds its last value, tables and counters are unchanged.
- Simultaneous lookup and update at the same index: the lookup returns the pre-update value (no bypass). The write is visible from the next cycle.
- Back-to-back resolutions on consecutive cycles are each processed. The redirect pulses are independent; a second fallo keeps redirigir high with the new pc_redir.
- Reset asserted mid-operation: all state clears immediately, and a pending redirect is dropped.
- PC addition wraps modulo 2^32: 0xFFFFFFFC + 4 = 0x00000000.

Test Plan:
- Reset then lookup pc=0x100 -> pred_tomado=0, pred_destino=0x104; counters 0; redirigir=0.
- Resolve pc=0x100, taken, dest=0x40, pred_dest=0x104 -> next cycle redirigir=1, pc_redir=0x40; total_fallos=1; bht=10. A subsequent lookup of 0x100 gives pred_tomado=1, pred_destino=0x40.
- Four taken resolutions of 0x100, each predicted correctly after the first -> bht saturates at 11. Then one not-taken with pred_dest=0x40 -> redirigir=1, pc_redir=0x104, bht=10, prediction still taken.
- Alias test: train 0x100 taken, then lookup 0x140 (same index, different tag) -> pred_tomado=0, pred_destino=0x144.
- Lookup and resolve 0x100 in the same cycle (first-time taken) -> same-cycle pred_tomado=0; next cycle pred_tomado=1.
- Preload total_fallos near all-ones via repeated mispredicts, or force CNT_W=4 -> the count stops at 0xF. Assert rst_n low while redirigir=1 -> redirigir=0 immediately and all tables clear.
